lut_1058_bist: RTL and testbench
================================

LUT_1058_BIST -- requirements
Module: lut_1058_bist

Interface
REQ-001 The module SHALL have parameter TRUTH, default 16'h1058, giving the expected LUT output: bit k is the expected s for input code k (set codes 3, 4, 6, 12).
REQ-002 The module SHALL have parameter SETTLE, default 2, range 1..15, giving the wait cycles between driving b and sampling s.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The module SHALL have port start, input, 1 bit: request a full sweep; level-sampled in IDLE.
REQ-006 The module SHALL have port s, input, 1 bit: the response of the LUT under test.
REQ-007 The module SHALL have port b, output, 4 bits: the code driven to the LUT under test; registered.
REQ-008 The module SHALL have port busy, output, 1 bit: high while a sweep is in progress (WAIT or SAMPLE).
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a sweep.
REQ-010 The module SHALL have port pass, output, 1 bit: high when the last completed sweep had zero mismatches.
REQ-011 The module SHALL have port err_one_cnt, output, 5 bits: count of codes where s was expected 1 and read 0.
REQ-012 The module SHALL have port err_zero_cnt, output, 5 bits: count of codes where s was expected 0 and read 1.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, SAMPLE and DONE, encoded in a registered state variable.
REQ-014 In IDLE with start=1, the next edge SHALL set b=0, clear the settle counter, clear err_one_cnt, err_zero_cnt and pass, and enter WAIT.
REQ-015 In IDLE with start=0, the FSM SHALL stay in IDLE and hold b, pass and both counters.
REQ-016 WAIT SHALL last exactly SETTLE cycles, counted by a 4-bit settle counter, then enter SAMPLE.
REQ-017 SAMPLE SHALL last exactly one cycle.
REQ-018 On the SAMPLE edge with TRUTH[b]=1 and s=0, err_one_cnt SHALL increment.
REQ-019 On the SAMPLE edge with TRUTH[b]=0 and s=1, err_zero_cnt SHALL increment.
REQ-020 On the SAMPLE edge with b<15, b SHALL increment by one, the settle counter SHALL clear, and the FSM SHALL enter WAIT.
REQ-021 On the SAMPLE edge with b=15, b SHALL hold at 15 and the FSM SHALL enter DONE; b SHALL never wrap during a sweep.
REQ-022 In DONE: done=1 and pass=(err_one_cnt==0 && err_zero_cnt==0), registered with the final counts included; the next edge SHALL enter IDLE.
REQ-023 done SHALL be high for exactly one cycle per sweep.
REQ-024 pass and both counters SHALL hold their values until the next accepted start.
REQ-025 busy SHALL be 1 exactly in WAIT and SAMPLE.
REQ-026 start SHALL be ignored in WAIT, SAMPLE and DONE; no restart or counter clear mid-sweep.
REQ-027 If start is held high through DONE, a new sweep SHALL begin on the first IDLE edge.
REQ-028 done SHALL be high on the 16*(SETTLE+1)-th edge after the edge that accepted start (48 for SETTLE=2).
REQ-029 The counters SHALL be 5 bits and reach at most 16; no saturation logic is required.
REQ-030 All outputs SHALL be registered; s SHALL be used only in SAMPLE.

Reset
REQ-031 When rst_n=0 at a rising edge, the next state SHALL be: FSM=IDLE, b=0, busy=0, done=0, pass=0, err_one_cnt=0, err_zero_cnt=0, settle counter=0.
REQ-032 Reset SHALL override start and apply in any state, including mid-sweep, discarding any partial counts.
REQ-033 No output SHALL change asynchronously to clk.

Verification
REQ-034 Correct LUT (s=TRUTH[b]), SETTLE=2, start pulsed one cycle -> b steps 0..15; done pulses after 48 edges; pass=1; both counters 0.
REQ-035 s stuck at 0 -> err_one_cnt=4, err_zero_cnt=0, pass=0.
REQ-036 s stuck at 1 -> err_one_cnt=0, err_zero_cnt=12, pass=0.
REQ-037 Inverted LUT (s=~TRUTH[b]) -> err_one_cnt=4, err_zero_cnt=12; a single fault at code 12 only -> err_one_cnt=1, err_zero_cnt=0.
REQ-038 start re-pulsed mid-sweep -> ignored, still exactly one done after 48 edges; start held high -> back-to-back sweeps with done spaced 49 cycles apart.
REQ-039 rst_n low for one edge while b=7 in WAIT -> all outputs at reset values, FSM in IDLE; a following start gives a clean full sweep with correct counts.

Source files
------------

// File: rtl/lut_1058_bist.sv
// lut_1058_bist
// Built-in self test for a 4-input LUT. The tester drives every code 0..15
// onto b, waits SETTLE cycles, samples the LUT response s and compares it
// against the expected truth table TRUTH. Mismatches are counted separately
// for "expected 1, read 0" and "expected 0, read 1".
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst_n        : synchronous active-low reset
//   start        : sweep request, level-sampled only while idle
//   s            : response of the LUT under test
//   b[3:0]       : code driven to the LUT under test
//   busy         : sweep in progress (WAIT or SAMPLE)
//   done         : one-cycle pulse at the end of a sweep
//   pass         : last completed sweep had no mismatches
//   err_one_cnt  : codes expected 1 but read 0
//   err_zero_cnt : codes expected 0 but read 1
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; results of the last sweep are held
// WAIT   | b is driven, settle counter running for SETTLE cycles
// SAMPLE | s is compared against TRUTH[b]; step b or finish
// DONE   | done pulse, pass reflects the final counts; back to IDLE

module lut_1058_bist #(
    parameter logic [15:0] TRUTH  = 16'h1058,
    parameter int          SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       s,
    output logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_one_cnt,
    output logic [4:0] err_zero_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // The settle counter counts up from 0; WAIT ends on its last value.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [3:0] settle_cnt, settle_cnt_nxt;
    logic [3:0] b_nxt;
    logic       busy_nxt;
    logic       done_nxt;
    logic       pass_nxt;
    logic [4:0] err_one_nxt;
    logic [4:0] err_zero_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            settle_cnt   <= 4'd0;
            b            <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_one_cnt  <= 5'd0;
            err_zero_cnt <= 5'd0;
        end else begin
            state        <= state_nxt;
            settle_cnt   <= settle_cnt_nxt;
            b            <= b_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            pass         <= pass_nxt;
            err_one_cnt  <= err_one_nxt;
            err_zero_cnt <= err_zero_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        b_nxt          = b;
        done_nxt       = 1'b0;
        pass_nxt       = pass;
        err_one_nxt    = err_one_cnt;
        err_zero_nxt   = err_zero_cnt;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    b_nxt          = 4'd0;
                    settle_cnt_nxt = 4'd0;
                    err_one_nxt    = 5'd0;
                    err_zero_nxt   = 5'd0;
                    pass_nxt       = 1'b0;
                    state_nxt      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = ST_SAMPLE;
                end else begin
                    settle_cnt_nxt = settle_cnt + 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (TRUTH[b] && !s) begin
                    err_one_nxt = err_one_cnt + 5'd1;
                end
                if (!TRUTH[b] && s) begin
                    err_zero_nxt = err_zero_cnt + 5'd1;
                end
                if (b != 4'd15) begin
                    b_nxt          = b + 4'd1;
                    settle_cnt_nxt = 4'd0;
                    state_nxt      = ST_WAIT;
                end else begin
                    // pass is registered together with done, so it must
                    // see the counts including this last sample.
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_one_nxt == 5'd0) && (err_zero_nxt == 5'd0);
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == ST_WAIT) || (state_nxt == ST_SAMPLE);
    end

endmodule

// File: tb/tb_lut_1058_bist.sv
// tb_lut_1058_bist
// Directed bench for lut_1058_bist with the default TRUTH/SETTLE. A small
// LUT model drives s from b in one of several fault modes; each sweep is
// checked for latency, code stepping, counts, pass and the done pulse.

module tb_lut_1058_bist;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       s;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_one_cnt;
    logic [4:0] err_zero_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 0;

    // Expected set codes 3, 4, 6, 12.
    logic [15:0] truth = 16'h1058;

    lut_1058_bist dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .s            (s),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_one_cnt  (err_one_cnt),
        .err_zero_cnt (err_zero_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // LUT under test: 0 good, 1 stuck-0, 2 stuck-1, 3 inverted, 4 fault at 12.
    always_comb begin
        s = truth[b];
        case (mode)
            1:       s = 1'b0;
            2:       s = 1'b1;
            3:       s = ~truth[b];
            4:       s = (b == 4'd12) ? ~truth[b] : truth[b];
            default: s = truth[b];
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full sweep. restart_at >= 0 pulses start again that many edges
    // after the accepting edge, which the DUT must ignore.
    task automatic sweep(input string tag, input int m, input int e1, input int e0,
                         input logic ep, input int restart_at);
        int edges;
        int bad;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        bad   = 0;
        while (!done && edges < 200) begin
            // 3 cycles per code with SETTLE=2
            if (b !== 4'(edges / 3) || busy !== 1'b1) bad++;
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = (edges == restart_at);
        end
        start = 1'b0;
        chk({tag, "_latency"}, edges, 48);
        chk({tag, "_bseq"}, bad, 0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_b_end"}, b, 15);
        chk({tag, "_err_one"}, err_one_cnt, e1);
        chk({tag, "_err_zero"}, err_zero_cnt, e0);
        chk({tag, "_pass"}, pass, ep);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, done, 0);
        repeat (4) @(negedge clk);
        chk({tag, "_hold_one"}, err_one_cnt, e1);
        chk({tag, "_hold_zero"}, err_zero_cnt, e0);
        chk({tag, "_hold_pass"}, pass, ep);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_done(input string tag, output int at);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, done, 1);
        at = cyc;
    endtask

    initial begin
        int t1;
        int t2;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_b", b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_one", err_one_cnt, 0);
        chk("rst_zero", err_zero_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", busy, 0);

        sweep("good",    0, 0,  0, 1'b1, -1);
        sweep("stuck0",  1, 4,  0, 1'b0, -1);
        sweep("stuck1",  2, 0, 12, 1'b0, -1);
        sweep("invert",  3, 4, 12, 1'b0, -1);
        sweep("fault12", 4, 1,  0, 1'b0, -1);
        sweep("restart", 0, 0,  0, 1'b1, 20);

        // start held high: DONE -> IDLE -> accept, so done repeats every
        // 50 edges (49 cycles between pulses).
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        wait_done("b2b_first", t1);
        @(negedge clk);
        wait_done("b2b_second", t2);
        start = 1'b0;
        chk("b2b_period", t2 - t1, 50);
        chk("b2b_pass", pass, 1);
        repeat (4) @(negedge clk);
        chk("b2b_stop", busy, 0);

        // Reset mid-sweep while b=7 in WAIT; stuck-1 makes the partial
        // zero-error count non-zero before reset.
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(b == 4'd7 && busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach_b7", b, 7);
        chk("mid_partial_zero", err_zero_cnt, 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_b", b, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_pass", pass, 0);
        chk("mid_rst_one", err_one_cnt, 0);
        chk("mid_rst_zero", err_zero_cnt, 0);
        repeat (3) @(negedge clk);
        chk("mid_rst_idle", busy, 0);
        sweep("after_rst", 0, 0, 0, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
